// File: rtl/dp_ram_fifo_ctrl_pkg.sv
// Shared constants for the dual-port RAM FIFO controller and its output buffer.
package dp_ram_pkg;

  // Read latency of the RAM macro: QA is valid the cycle after CEA is sampled.
  localparam int RD_LAT = 1;

  // Entries in the capture/skid buffer that sits behind the RAM read port.
  localparam int OUT_DEPTH = 2;

  // Strobe polarities on the macro pins.
  localparam logic CE_ACTIVE = 1'b1;
  localparam logic BWB_WRITE = 1'b1;

endpackage

// File: rtl/dp_ram_fifo_outbuf.sv
// Two-entry capture/skid buffer. Words returned by the RAM read port land at
// the tail; the head drives the pop stream. A capture and a pop may happen in
// the same cycle. Clearing drops both entries.
module dp_ram_fifo_outbuf
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_count;
  logic                  w_pop;

  assign w_pop       = i_out_ready && (r_count != 2'd0);
  assign o_out_valid = (r_count != 2'd0);
  assign o_out_data  = r_head;
  assign o_count     = r_count;

  // Capture at the tail, pop from the head, shifting the tail forward on a pop.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({i_in_valid, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_in_data;
          else                 r_tail <= i_in_data;
          if (r_count != 2'(OUT_DEPTH)) r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_in_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller driving one dual-port RAM macro (port A read, port B write).
// Both streams use plain valid/ready: a word moves on a cycle where valid and
// ready are both high at the clock edge; valid never depends on ready.
// push_ready is registered from level, so it ignores a pop in the same cycle.
// Total capacity is the RAM depth plus the two output buffer entries.
module dp_ram_fifo_ctrl
  import dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic [ADDR_WIDTH-1:0] mem_aa,
  output logic                  mem_cea,
  input  logic [DATA_WIDTH-1:0] mem_qa,
  output logic [ADDR_WIDTH-1:0] mem_ab,
  output logic                  mem_ceb,
  output logic [DATA_WIDTH-1:0] mem_db,
  output logic [DATA_WIDTH-1:0] mem_bwb
);

  localparam int                  RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] DEPTH   = (ADDR_WIDTH+2)'(RAM_DEPTH + OUT_DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_mem_count;
  logic                  r_inflight;
  logic [ADDR_WIDTH+1:0] r_level;
  logic                  r_push_ready;

  logic [1:0]            w_ob_count;
  logic                  w_pop_valid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_capture;
  logic [2:0]            w_occ;
  logic [ADDR_WIDTH+1:0] w_level_next;

  assign w_push    = push_valid && r_push_ready && !flush;
  assign w_pop     = pop_ready && w_pop_valid && !flush;
  assign w_capture = r_inflight && !flush;

  // Buffer slots already spoken for, crediting a head leaving this cycle.
  // The credit lets a read issue behind a pop, which keeps a stream moving at
  // one word per cycle and guarantees the RAM is never completely full while
  // a buffer slot is free, so a read never targets the word being written.
  assign w_occ = {1'b0, w_ob_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  // mem_count only counts writes from earlier edges, so this cycle's write is
  // never read back in the same cycle.
  assign w_issue = (r_mem_count != '0) && (w_occ < 3'(OUT_DEPTH)) && !flush;

  assign w_level_next = flush ? '0
                      : r_level + (ADDR_WIDTH+2)'(w_push) - (ADDR_WIDTH+2)'(w_pop);

  assign mem_ceb    = w_push  ? CE_ACTIVE : ~CE_ACTIVE;
  assign mem_cea    = w_issue ? CE_ACTIVE : ~CE_ACTIVE;
  assign mem_ab     = r_wr_ptr;
  assign mem_aa     = r_rd_ptr;
  assign mem_db     = push_data;
  assign mem_bwb    = w_push ? {DATA_WIDTH{BWB_WRITE}} : {DATA_WIDTH{~BWB_WRITE}};
  assign push_ready = r_push_ready;
  assign pop_valid  = w_pop_valid;
  assign level      = r_level;

  dp_ram_fifo_outbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outbuf (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_clr       (flush),
    .i_in_valid  (w_capture),
    .i_in_data   (mem_qa),
    .o_out_valid (w_pop_valid),
    .i_out_ready (pop_ready && !flush),
    .o_out_data  (pop_data),
    .o_count     (w_ob_count)
  );

  // Pointers, RAM occupancy, in-flight read flag, level and registered push_ready.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mem_count  <= '0;
      r_inflight   <= 1'b0;
      r_level      <= '0;
      r_push_ready <= 1'b1;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mem_count  <= '0;
      r_inflight   <= 1'b0;
      r_level      <= '0;
      r_push_ready <= 1'b1;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_mem_count  <= r_mem_count + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_issue);
      r_inflight   <= w_issue;
      r_level      <= w_level_next;
      r_push_ready <= (w_level_next < DEPTH);
    end
  end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl with a behavioural RAM macro beside it.
module tb_dp_ram_fifo_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;

  // ---------------- clock / reset / DUT ----------------
  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_data = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [DW-1:0] pop_data;
  logic [AW+1:0] level;
  logic [AW-1:0] mem_aa;
  logic          mem_cea;
  logic [DW-1:0] mem_qa = '0;
  logic [AW-1:0] mem_ab;
  logic          mem_ceb;
  logic [DW-1:0] mem_db;
  logic [DW-1:0] mem_bwb;

  always #5 CLK = ~CLK;

  dp_ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .level(level),
    .mem_aa(mem_aa), .mem_cea(mem_cea), .mem_qa(mem_qa),
    .mem_ab(mem_ab), .mem_ceb(mem_ceb), .mem_db(mem_db), .mem_bwb(mem_bwb)
  );

  // RAM macro model: one-cycle read latency, bit-masked write.
  logic [DW-1:0] ram [1<<AW];
  always @(posedge CLK) begin
    if (mem_cea) mem_qa <= ram[mem_aa];
    if (mem_ceb) ram[mem_ab] <= (ram[mem_ab] & ~mem_bwb) | (mem_db & mem_bwb);
  end

  // ---------------- bookkeeping ----------------
  int            n_checks = 0;
  int            n_fail = 0;
  int            rcvd = 0;
  int            sent = 0;
  int            wr_wraps = 0;
  int            rd_wraps = 0;
  logic          issued;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard (samples on the falling edge) ----------------
  always @(negedge CLK) begin
    if (RST || flush) begin
      exp_q.delete();
    end else begin
      if (mem_cea === 1'b1 && mem_ceb === 1'b1) begin
        n_checks++;
        if (mem_aa == mem_ab) begin
          n_fail++;
          $display("FAIL addr_collision: aa=%0h ab=%0h", mem_aa, mem_ab);
        end
      end
      if (pop_valid === 1'b1 && pop_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got %0h, expected nothing", pop_data);
        end else begin
          check("pop_data_order", 64'(pop_data), 64'(exp_q.pop_front()));
        end
        rcvd++;
      end
      if (push_valid && push_ready === 1'b1) exp_q.push_back(push_data);
      if (mem_ceb === 1'b1 && mem_ab == '1) wr_wraps++;
      if (mem_cea === 1'b1 && mem_aa == '1) rd_wraps++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    tick();
    RST = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst, flsh, pv;
    logic [DW-1:0] pd;
    logic          pr;
    logic          chk, chk_data;
    logic          e_pready, e_pvalid;
    logic [DW-1:0] e_pdata;
    logic [AW+1:0] e_level;
    logic          e_cea, e_ceb;
    logic [AW-1:0] e_aa, e_ab;
  } vec_t;

  function automatic vec_t mk(input logic rst, flsh, pv, input logic [DW-1:0] pd, input logic pr,
                              input logic chk, chk_data, e_pready, e_pvalid,
                              input logic [DW-1:0] e_pdata, input logic [AW+1:0] e_level,
                              input logic e_cea, e_ceb, input logic [AW-1:0] e_aa, e_ab);
    vec_t v;
    v.rst = rst; v.flsh = flsh; v.pv = pv; v.pd = pd; v.pr = pr;
    v.chk = chk; v.chk_data = chk_data; v.e_pready = e_pready; v.e_pvalid = e_pvalid;
    v.e_pdata = e_pdata; v.e_level = e_level; v.e_cea = e_cea; v.e_ceb = e_ceb;
    v.e_aa = e_aa; v.e_ab = e_ab;
    return v;
  endfunction

  vec_t vecs[16];

  // ---------------- main sequence ----------------
  initial begin
    // reset row, ten idle rows, then a single push traced to its pop
    vecs[0] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++)
      vecs[i] = mk(0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 32'hA5A5A5A5, 1,  1, 1, 1, 0, 0,            0, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0,            1,  1, 1, 1, 0, 0,            1, 1, 0, 0, 1);
    vecs[13] = mk(0, 0, 0, 0,            1,  1, 1, 1, 0, 0,            1, 0, 0, 1, 1);
    vecs[14] = mk(0, 0, 0, 0,            1,  1, 1, 1, 1, 32'hA5A5A5A5, 1, 0, 0, 1, 1);
    vecs[15] = mk(0, 0, 0, 0,            1,  1, 0, 1, 0, 0,            0, 0, 0, 1, 1);

    tick();
    for (int i = 0; i < 16; i++) begin
      RST = vecs[i].rst; flush = vecs[i].flsh; push_valid = vecs[i].pv;
      push_data = vecs[i].pd; pop_ready = vecs[i].pr;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d_push_ready", i), 64'(push_ready), 64'(vecs[i].e_pready));
        check($sformatf("v%0d_pop_valid", i),  64'(pop_valid),  64'(vecs[i].e_pvalid));
        check($sformatf("v%0d_level", i),      64'(level),      64'(vecs[i].e_level));
        check($sformatf("v%0d_mem_cea", i),    64'(mem_cea),    64'(vecs[i].e_cea));
        check($sformatf("v%0d_mem_ceb", i),    64'(mem_ceb),    64'(vecs[i].e_ceb));
        check($sformatf("v%0d_mem_aa", i),     64'(mem_aa),     64'(vecs[i].e_aa));
        check($sformatf("v%0d_mem_ab", i),     64'(mem_ab),     64'(vecs[i].e_ab));
        check($sformatf("v%0d_mem_bwb", i),    64'(mem_bwb),    vecs[i].e_ceb ? 64'hFFFFFFFF : 64'h0);
        if (vecs[i].chk_data)
          check($sformatf("v%0d_pop_data", i), 64'(pop_data),   64'(vecs[i].e_pdata));
        if (vecs[i].e_ceb)
          check($sformatf("v%0d_mem_db", i),   64'(mem_db),     64'(vecs[i].pd));
      end
      @(posedge CLK);
      #1;
    end

    // fill to capacity with the consumer stalled, reject the 19th push
    do_reset();
    rcvd = 0;
    for (int i = 0; i < 18; i++) begin
      push_valid = 1'b1; push_data = DW'(i);
      #1;
      check($sformatf("fill_ready_%0d", i), 64'(push_ready), 64'd1);
      tick();
    end
    push_data = 32'd99;
    #1;
    check("full_level", 64'(level), 64'd18);
    check("full_push_ready", 64'(push_ready), 64'd0);
    check("full_no_write", 64'(mem_ceb), 64'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      check("full_hold_ready", 64'(push_ready), 64'd0);
      check("full_hold_level", 64'(level), 64'd18);
      tick();
    end
    // full: pop and push together, only the pop goes through
    pop_ready = 1'b1;
    #1;
    check("fullpop_pop_valid", 64'(pop_valid), 64'd1);
    check("fullpop_pop_data", 64'(pop_data), 64'd0);
    check("fullpop_push_ready", 64'(push_ready), 64'd0);
    check("fullpop_no_write", 64'(mem_ceb), 64'd0);
    tick();
    pop_ready = 1'b0;
    #1;
    check("after_pop_push_ready", 64'(push_ready), 64'd1);
    check("after_pop_level", 64'(level), 64'd17);
    check("after_pop_write", 64'(mem_ceb), 64'd1);
    tick();
    push_valid = 1'b0;
    #1;
    check("refull_level", 64'(level), 64'd18);
    pop_ready = 1'b1;
    for (int c = 0; c < 100 && level != 0; c++) tick();
    pop_ready = 1'b0;
    check("drain_count", 64'(rcvd), 64'd19);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_level", 64'(level), 64'd0);

    // 100-word stream with random consumer stalls
    do_reset();
    rcvd = 0; sent = 0; wr_wraps = 0; rd_wraps = 0;
    for (int c = 0; c < 3000 && (sent < 100 || rcvd < 100); c++) begin
      push_valid = (sent < 100);
      push_data  = $urandom();
      pop_ready  = ($urandom_range(0, 3) != 0);
      #1;
      if (push_valid && push_ready) sent++;
      @(posedge CLK);
      #1;
    end
    push_valid = 1'b0; pop_ready = 1'b0;
    check("stream_sent", 64'(sent), 64'd100);
    check("stream_rcvd", 64'(rcvd), 64'd100);
    check("stream_wr_wraps_ge5", 64'(wr_wraps >= 5), 64'd1);
    check("stream_rd_wraps_ge5", 64'(rd_wraps >= 5), 64'd1);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // flush the cycle after a read issue with 5 words held
    do_reset();
    rcvd = 0;
    for (int i = 0; i < 6; i++) begin
      push_valid = 1'b1; push_data = 32'h200 + DW'(i);
      tick();
    end
    push_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("preflush_level", 64'(level), 64'd6);
    pop_ready = 1'b1;
    #1;
    check("preflush_pop_valid", 64'(pop_valid), 64'd1);
    check("preflush_pop_data", 64'(pop_data), 64'h200);
    issued = mem_cea;
    tick();
    pop_ready = 1'b0;
    for (int c = 0; c < 4 && !issued; c++) begin
      #1;
      issued = mem_cea;
      tick();
    end
    check("preflush_read_issued", 64'(issued), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_cycle_level", 64'(level), 64'd5);
    tick();
    flush = 1'b0;
    check("postflush_level", 64'(level), 64'd0);
    check("postflush_pop_valid", 64'(pop_valid), 64'd0);
    check("postflush_push_ready", 64'(push_ready), 64'd1);
    pop_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("postflush_quiet", 64'(pop_valid), 64'd0);
      tick();
    end
    push_valid = 1'b1; push_data = 32'h1;
    tick();
    push_valid = 1'b0;
    for (int c = 0; c < 10 && rcvd < 2; c++) tick();
    pop_ready = 1'b0;
    check("postflush_rcvd", 64'(rcvd), 64'd2);
    check("postflush_queue_empty", 64'(exp_q.size()), 64'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
